// File: rtl/packet_rr_scheduler_if.sv
// Ingress packet-memory and egress Avalon-ST signal bundle for packet_rr_scheduler.
// The slave modport is the scheduler's view; the master modport is the source/sink side.
interface packet_rr_scheduler_if #(
    parameter int pNUM_PORTS  = 4,
    parameter int pDATA_WIDTH = 8,
    parameter int pLEN_WIDTH  = 11
);
    logic [pNUM_PORTS-1:0]             iempty_fifo;
    logic [pNUM_PORTS*pLEN_WIDTH-1:0]  ilen;
    logic [pNUM_PORTS-1:0]             ivalid;
    logic [pNUM_PORTS*pDATA_WIDTH-1:0] idata;
    logic [pNUM_PORTS-1:0]             isop;
    logic [pNUM_PORTS-1:0]             ieop;
    logic [pNUM_PORTS-1:0]             ierror;
    logic [pNUM_PORTS-1:0]             ird_en;
    logic [pNUM_PORTS-1:0]             oready;
    logic                              iready;
    logic                              ovalid;
    logic [pDATA_WIDTH-1:0]            odata;
    logic                              ostartofpacket;
    logic                              oendofpacket;
    logic                              oerror;
    logic [3:0]                        ochannel;
    logic                              olen_err;
    logic                              otimeout;

    modport master (
        output iempty_fifo, ilen, ivalid, idata, isop, ieop, ierror, iready,
        input  ird_en, oready, ovalid, odata, ostartofpacket, oendofpacket,
               oerror, ochannel, olen_err, otimeout
    );

    modport slave (
        input  iempty_fifo, ilen, ivalid, idata, isop, ieop, ierror, iready,
        output ird_en, oready, ovalid, odata, ostartofpacket, oendofpacket,
               oerror, ochannel, olen_err, otimeout
    );
endinterface

// File: rtl/packet_rr_scheduler.sv
// Round-robin scheduler granting one ingress packet memory per packet onto a single Avalon-ST egress.
// Optional XFER stall watchdog is enabled by defining PKT_SCHED_WATCHDOG_EN.
module packet_rr_scheduler #(
    parameter int pNUM_PORTS   = 4,
    parameter int pDATA_WIDTH  = 8,
    parameter int pLEN_WIDTH   = 11,
    parameter int pWDOG_CYCLES = 4096
) (
    input  logic                 iclk,
    input  logic                 irst,
    packet_rr_scheduler_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, XFER} state_t;

    state_t                 state, state_nxt;
    logic [3:0]             grant, grant_nxt, rr_ptr, rr_nxt, grant_inc;
    logic [3:0]             pick, hi_pick, lo_pick;
    logic                   any_req, hi_found;
    logic                   sel_valid, sel_sop, sel_eop, sel_error;
    logic [pDATA_WIDTH-1:0] sel_data;
    logic [pLEN_WIDTH-1:0]  sel_len, exp_len, beat_cnt;
    logic                   xfer, beat_acc, eop_acc, len_mis;
    logic                   len_err_p1, len_err_nxt, wdog_hit;

    function automatic logic [pLEN_WIDTH-1:0] sat_inc(input logic [pLEN_WIDTH-1:0] v);
        return (&v) ? v : v + pLEN_WIDTH'(1);
    endfunction

    always_comb begin
        sel_valid = 1'b0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        sel_error = 1'b0;
        sel_data  = '0;
        sel_len   = '0;
        for (int i = 0; i < pNUM_PORTS; i++) begin
            if (grant == 4'(i)) begin
                sel_valid = bus.ivalid[i];
                sel_sop   = bus.isop[i];
                sel_eop   = bus.ieop[i];
                sel_error = bus.ierror[i];
                sel_data  = bus.idata[i*pDATA_WIDTH +: pDATA_WIDTH];
                sel_len   = bus.ilen[i*pLEN_WIDTH +: pLEN_WIDTH];
            end
        end
    end

    // Descending scan so the lowest qualifying index wins: first at/after rr_ptr, else wrap to lowest.
    always_comb begin
        any_req  = 1'b0;
        hi_found = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int i = pNUM_PORTS - 1; i >= 0; i--) begin
            if (!bus.iempty_fifo[i]) begin
                any_req = 1'b1;
                lo_pick = 4'(i);
                if (4'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_pick  = 4'(i);
                end
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
    end

    assign grant_inc = (grant == 4'(pNUM_PORTS - 1)) ? 4'd0 : grant + 4'd1;
    assign xfer      = (state == XFER);
    assign beat_acc  = xfer && sel_valid && bus.iready;
    assign eop_acc   = beat_acc && sel_eop;
    assign len_mis   = (sat_inc(beat_cnt) != exp_len);

`ifdef PKT_SCHED_WATCHDOG_EN
    localparam int             WDW       = $clog2(pWDOG_CYCLES + 1);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(pWDOG_CYCLES - 1);
    logic [WDW-1:0]            stall_cnt;

    always_ff @(posedge iclk) begin
        if (irst || !xfer || beat_acc) stall_cnt <= '0;
        else                           stall_cnt <= stall_cnt + WDW'(1);
    end
    assign wdog_hit = xfer && !beat_acc && (stall_cnt == WDOG_LAST);
`else
    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        rr_nxt      = rr_ptr;
        len_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nxt = pick;
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = XFER;
            XFER: begin
                if (eop_acc) begin
                    len_err_nxt = len_mis;
                    rr_nxt      = grant_inc;
                    state_nxt   = IDLE;
                end else if (wdog_hit) begin
                    rr_nxt    = grant_inc;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            len_err_p1 <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            rr_ptr     <= rr_nxt;
            len_err_p1 <= len_err_nxt;
        end
    end

    // Descriptor length and beat count only matter inside a packet; LOAD initialises both.
    always_ff @(posedge iclk) begin
        if (state == LOAD) begin
            exp_len  <= sel_len;
            beat_cnt <= '0;
        end else if (beat_acc) begin
            beat_cnt <= sat_inc(beat_cnt);
        end
    end

    always_comb begin
        bus.ird_en = '0;
        bus.oready = '0;
        for (int i = 0; i < pNUM_PORTS; i++) begin
            if (grant == 4'(i)) begin
                bus.ird_en[i] = (state == LOAD);
                bus.oready[i] = xfer && bus.iready;
            end
        end
    end

    assign bus.ovalid         = xfer && sel_valid;
    assign bus.odata          = xfer ? sel_data : '0;
    assign bus.ostartofpacket = xfer && sel_sop;
    assign bus.oendofpacket   = xfer && sel_eop;
    assign bus.oerror         = xfer && (sel_error || (sel_eop && len_mis));
    assign bus.ochannel       = grant;
    assign bus.olen_err       = len_err_p1;
    assign bus.otimeout       = wdog_hit;

endmodule

// File: tb/tb_packet_rr_scheduler.sv
// Bench for packet_rr_scheduler: per-port source queues feed the DUT and a round-robin
// reference model fills a scoreboard of expected egress beats and descriptor pops.
`timescale 1ns/1ps
module tb_packet_rr_scheduler;
    localparam int NP = 4;
    localparam int DW = 8;
    localparam int LW = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    packet_rr_scheduler_if #(.pNUM_PORTS(NP), .pDATA_WIDTH(DW), .pLEN_WIDTH(LW)) bus ();

    packet_rr_scheduler #(
        .pNUM_PORTS(NP), .pDATA_WIDTH(DW), .pLEN_WIDTH(LW), .pWDOG_CYCLES(16)
    ) dut (
        .iclk(clk),
        .irst(rst),
        .bus (bus)
    );

    typedef struct packed { logic [7:0] data; logic sop; logic eop; logic err; } src_t;
    typedef struct packed { logic [3:0] chan; logic [7:0] data; logic sop; logic eop; logic err; } beat_t;
    typedef struct packed { beat_t beat; logic mis; } exp_t;
    typedef struct packed {
        logic valid; logic acc; beat_t beat; logic [NP-1:0] rd_en; logic [NP-1:0] ready;
        logic rdy_in; logic len_err; logic tmo;
    } obs_t;

    src_t          beat_q    [NP][$];
    src_t          ref_q     [NP][$];
    logic [LW-1:0] desc_q    [NP][$];
    int            mdl_len_q [NP][$];
    int            mdl_n_q   [NP][$];
    exp_t          sb [$];
    int            pop_exp [$];
    int            sent    [NP];
    int            vld_lim [NP];
    int            mdl_ptr, rdy_mode, cyc, n_run, n_fail;

    task automatic drive();
        logic [NP-1:0]    empt, vld, sop, eop, err;
        logic [NP*LW-1:0] len;
        logic [NP*DW-1:0] dat;
        src_t             h;
        empt = '1; vld = '0; sop = '0; eop = '0; err = '0; len = '0; dat = '0;
        for (int p = 0; p < NP; p++) begin
            if (desc_q[p].size() > 0) begin
                empt[p] = 1'b0;
                len[p*LW +: LW] = desc_q[p][0];
            end
            if (beat_q[p].size() > 0 && (vld_lim[p] < 0 || sent[p] < vld_lim[p])) begin
                h = beat_q[p][0];
                vld[p] = 1'b1;
                dat[p*DW +: DW] = h.data;
                sop[p] = h.sop;
                eop[p] = h.eop;
                err[p] = h.err;
            end
        end
        bus.iempty_fifo = empt;
        bus.ilen        = len;
        bus.ivalid      = vld;
        bus.idata       = dat;
        bus.isop        = sop;
        bus.ieop        = eop;
        bus.ierror      = err;
        case (rdy_mode)
            0:       bus.iready = 1'b1;
            1:       bus.iready = cyc[0];
            default: bus.iready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Sample outputs mid-cycle, then update the source/descriptor models for the edge that follows.
    task automatic step(output obs_t o);
        logic [NP-1:0] acc_p, rd_p;
        @(negedge clk);
        o.valid     = bus.ovalid;
        o.rdy_in    = bus.iready;
        o.acc       = bus.ovalid & bus.iready;
        o.beat.chan = bus.ochannel;
        o.beat.data = bus.odata;
        o.beat.sop  = bus.ostartofpacket;
        o.beat.eop  = bus.oendofpacket;
        o.beat.err  = bus.oerror;
        o.rd_en     = bus.ird_en;
        o.ready     = bus.oready;
        o.len_err   = bus.olen_err;
        o.tmo       = bus.otimeout;
        acc_p = bus.oready & bus.ivalid;
        rd_p  = bus.ird_en;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (acc_p[p] && beat_q[p].size() > 0) begin
                beat_q[p].delete(0);
                sent[p]++;
            end
            if (rd_p[p] && desc_q[p].size() > 0) desc_q[p].delete(0);
        end
        cyc++;
        drive();
    endtask

    task automatic clear_all();
        for (int p = 0; p < NP; p++) begin
            beat_q[p].delete(); ref_q[p].delete(); desc_q[p].delete();
            mdl_len_q[p].delete(); mdl_n_q[p].delete();
            sent[p] = 0;
            vld_lim[p] = -1;
        end
        sb.delete();
        pop_exp.delete();
    endtask

    task automatic add_pkt(input int p, input int len, input int n, input bit with_sop, input int err_beat);
        src_t s;
        for (int b = 0; b < n; b++) begin
            s.data = 8'($urandom);
            s.sop  = with_sop && (b == 0);
            s.eop  = (b == n - 1);
            s.err  = (b == err_beat);
            beat_q[p].push_back(s);
            ref_q[p].push_back(s);
        end
        desc_q[p].push_back(LW'(len));
        mdl_len_q[p].push_back(len);
        mdl_n_q[p].push_back(n);
    endtask

    // Reference round-robin: every descriptor is queued up front, so the grant order is fixed now.
    task automatic build_expected();
        int   p, found, len, n;
        src_t r;
        exp_t e;
        do begin
            found = 0;
            p = 0;
            for (int i = 0; i < NP; i++) begin
                int q;
                q = (mdl_ptr + i) % NP;
                if (found == 0 && mdl_len_q[q].size() > 0) begin
                    found = 1;
                    p = q;
                end
            end
            if (found != 0) begin
                len = mdl_len_q[p].pop_front();
                n   = mdl_n_q[p].pop_front();
                pop_exp.push_back(p);
                for (int b = 0; b < n; b++) begin
                    r = ref_q[p].pop_front();
                    e.beat.chan = 4'(p);
                    e.beat.data = r.data;
                    e.beat.sop  = r.sop;
                    e.beat.eop  = r.eop;
                    e.mis       = r.eop && (n != len);
                    e.beat.err  = r.err | e.mis;
                    sb.push_back(e);
                end
                mdl_ptr = (p + 1) % NP;
            end
        end while (found != 0);
        drive();
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        clear_all();
        rdy_mode = 0;
        drive();
        repeat (3) step(o);
        rst = 1'b0;
        mdl_ptr = 0;
        for (int c = 0; c < 100; c++) begin
            step(o);
            n_run++;
            if (o.valid !== 1'b0 || o.rd_en !== '0 || o.ready !== '0 || o.len_err !== 1'b0 ||
                o.tmo !== 1'b0 || o.beat.chan !== 4'd0 || o.beat.sop !== 1'b0 || o.beat.eop !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: ovalid=%0b ird_en=%b oready=%b olen_err=%0b otimeout=%0b ochannel=%0d sop=%0b eop=%0b, required all 0",
                         c, o.valid, o.rd_en, o.ready, o.len_err, o.tmo, o.beat.chan, o.beat.sop, o.beat.eop);
            end
        end
    endtask

    task automatic test_rr_order();
        obs_t o; exp_t e; logic pend; logic [NP-1:0] exp_rd;
        clear_all();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < NP; p++) add_pkt(p, 5 + p, 5 + p, 1'b1, -1);
        build_expected();
        pend = 1'b0;
        for (int c = 0; c < 2000 && (sb.size() > 0 || pend); c++) begin
            step(o);
            n_run++;
            if (o.len_err !== pend) begin n_fail++; $display("FAIL rr_order olen_err cycle %0d: got %0b required %0b", c, o.len_err, pend); end
            pend = 1'b0;
            if (o.rd_en !== '0) begin
                exp_rd = (pop_exp.size() > 0) ? (4'b0001 << pop_exp.pop_front()) : 4'b0000;
                n_run++;
                if (o.rd_en !== exp_rd) begin n_fail++; $display("FAIL rr_order ird_en: got %b required %b", o.rd_en, exp_rd); end
            end
            if (o.acc) begin
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                n_run++;
                if (o.beat !== e.beat) begin n_fail++; $display("FAIL rr_order beat: got %h required %h", o.beat, e.beat); end
                pend = e.beat.eop & e.mis;
            end
        end
        n_run++;
        if (sb.size() != 0 || pop_exp.size() != 0) begin
            n_fail++; $display("FAIL rr_order drain: %0d beats and %0d pops left, required 0", sb.size(), pop_exp.size());
        end
    endtask

    task automatic test_two_ports();
        obs_t o; exp_t e; logic pend; logic [NP-1:0] exp_rd;
        clear_all();
        add_pkt(0, 64, 64, 1'b1, -1);
        add_pkt(2, 64, 64, 1'b1, -1);
        build_expected();
        pend = 1'b0;
        for (int c = 0; c < 2000 && (sb.size() > 0 || pend); c++) begin
            step(o);
            n_run++;
            if (o.len_err !== pend) begin n_fail++; $display("FAIL two_ports olen_err cycle %0d: got %0b required %0b", c, o.len_err, pend); end
            pend = 1'b0;
            if (o.rd_en !== '0) begin
                exp_rd = (pop_exp.size() > 0) ? (4'b0001 << pop_exp.pop_front()) : 4'b0000;
                n_run++;
                if (o.rd_en !== exp_rd) begin n_fail++; $display("FAIL two_ports ird_en: got %b required %b", o.rd_en, exp_rd); end
            end
            if (o.acc) begin
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                n_run++;
                if (o.beat !== e.beat) begin n_fail++; $display("FAIL two_ports beat: got %h required %h", o.beat, e.beat); end
                pend = e.beat.eop & e.mis;
            end
        end
        n_run++;
        if (sb.size() != 0 || pop_exp.size() != 0) begin
            n_fail++; $display("FAIL two_ports drain: %0d beats and %0d pops left, required 0", sb.size(), pop_exp.size());
        end
    endtask

    // Short packet, source-flagged error beat, and a zero-length descriptor whose packet lacks sop.
    task automatic test_len_err();
        obs_t o; exp_t e; logic pend; logic [NP-1:0] exp_rd; int n_lerr;
        clear_all();
        add_pkt(1, 64, 60, 1'b1, -1);
        add_pkt(2, 8, 8, 1'b1, 3);
        add_pkt(3, 0, 3, 1'b0, -1);
        build_expected();
        pend = 1'b0;
        n_lerr = 0;
        for (int c = 0; c < 2000 && (sb.size() > 0 || pend); c++) begin
            step(o);
            n_run++;
            if (o.len_err) n_lerr++;
            if (o.len_err !== pend) begin n_fail++; $display("FAIL len_err olen_err cycle %0d: got %0b required %0b", c, o.len_err, pend); end
            pend = 1'b0;
            if (o.rd_en !== '0) begin
                exp_rd = (pop_exp.size() > 0) ? (4'b0001 << pop_exp.pop_front()) : 4'b0000;
                n_run++;
                if (o.rd_en !== exp_rd) begin n_fail++; $display("FAIL len_err ird_en: got %b required %b", o.rd_en, exp_rd); end
            end
            if (o.acc) begin
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                n_run++;
                if (o.beat !== e.beat) begin n_fail++; $display("FAIL len_err beat: got %h required %h", o.beat, e.beat); end
                pend = e.beat.eop & e.mis;
            end
        end
        n_run++;
        if (sb.size() != 0 || pop_exp.size() != 0 || n_lerr != 2) begin
            n_fail++; $display("FAIL len_err drain: %0d beats left, %0d olen_err pulses, required 0 and 2", sb.size(), n_lerr);
        end
    endtask

    task automatic test_backpressure();
        obs_t o; exp_t e; logic pend; logic [NP-1:0] exp_rd, exp_rdy; int n_acc;
        clear_all();
        rdy_mode = 1;
        add_pkt(0, 64, 64, 1'b1, -1);
        add_pkt(1, 20, 20, 1'b1, -1);
        build_expected();
        pend = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 3000 && (sb.size() > 0 || pend); c++) begin
            if (c == 100) rdy_mode = 2;
            step(o);
            n_run++;
            if (o.len_err !== pend) begin n_fail++; $display("FAIL backpressure olen_err cycle %0d: got %0b required %0b", c, o.len_err, pend); end
            pend = 1'b0;
            if (o.rd_en !== '0) begin
                exp_rd = (pop_exp.size() > 0) ? (4'b0001 << pop_exp.pop_front()) : 4'b0000;
                n_run++;
                if (o.rd_en !== exp_rd) begin n_fail++; $display("FAIL backpressure ird_en: got %b required %b", o.rd_en, exp_rd); end
            end
            if (o.valid) begin
                exp_rdy = o.rdy_in ? (4'b0001 << o.beat.chan) : 4'b0000;
                n_run++;
                if (o.ready !== exp_rdy) begin n_fail++; $display("FAIL backpressure oready: got %b required %b", o.ready, exp_rdy); end
            end
            if (o.acc) begin
                n_acc++;
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                n_run++;
                if (o.beat !== e.beat) begin n_fail++; $display("FAIL backpressure beat: got %h required %h", o.beat, e.beat); end
                pend = e.beat.eop & e.mis;
            end
        end
        n_run++;
        if (sb.size() != 0 || n_acc != 84) begin
            n_fail++; $display("FAIL backpressure count: got %0d accepted beats required 84", n_acc);
        end
        rdy_mode = 0;
    endtask

    task automatic test_reset_mid();
        obs_t o; int got;
        clear_all();
        add_pkt(1, 64, 64, 1'b1, -1);
        drive();
        got = 0;
        for (int c = 0; c < 200 && got < 10; c++) begin
            step(o);
            if (o.acc) got++;
        end
        n_run++;
        if (got != 10) begin n_fail++; $display("FAIL reset_mid start: got %0d beats required 10", got); end
        rst = 1'b1;
        step(o);
        step(o);
        n_run++;
        if (o.valid !== 1'b0 || o.rd_en !== '0 || o.beat.chan !== 4'd0) begin
            n_fail++; $display("FAIL reset_mid abort: ovalid=%0b ird_en=%b ochannel=%0d required 0", o.valid, o.rd_en, o.beat.chan);
        end
        clear_all();
        drive();
        rst = 1'b0;
        mdl_ptr = 0;
        for (int c = 0; c < 20; c++) begin
            step(o);
            n_run++;
            if (o.valid !== 1'b0 || o.rd_en !== '0 || o.beat.chan !== 4'd0) begin
                n_fail++; $display("FAIL reset_mid idle cycle %0d: ovalid=%0b ird_en=%b ochannel=%0d required 0", c, o.valid, o.rd_en, o.beat.chan);
            end
        end
    endtask

`ifdef PKT_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        obs_t o; int last, tmo_seen, next_chan;
        clear_all();
        add_pkt(0, 64, 64, 1'b1, -1);
        add_pkt(1, 4, 4, 1'b1, -1);
        vld_lim[0] = 10;
        drive();
        last = -1000; tmo_seen = 0; next_chan = -1;
        for (int c = 0; c < 300 && next_chan < 0; c++) begin
            step(o);
            if (o.tmo && tmo_seen == 0) begin
                tmo_seen = 1;
                n_run++;
                if (c - last != 16) begin n_fail++; $display("FAIL watchdog delay: got %0d cycles required 16", c - last); end
            end
            if (o.acc) begin
                if (tmo_seen != 0) next_chan = int'(o.beat.chan);
                else               last = c;
            end
        end
        n_run++;
        if (next_chan != 1) begin n_fail++; $display("FAIL watchdog next_grant: got %0d required 1", next_chan); end
        clear_all();
        drive();
    endtask
`endif

    initial begin
        n_run = 0; n_fail = 0; cyc = 0; rdy_mode = 0; mdl_ptr = 0;
        test_reset();
        test_rr_order();
        test_two_ports();
        test_len_err();
        test_backpressure();
        test_reset_mid();
`ifdef PKT_SCHED_WATCHDOG_EN
        test_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
